conv3x3_engine: RTL

Consumes the three vertically aligned pixel columns produced each valid cycle by the 3x3 line buffer. It forms a sliding 3x3 window, multiplies it by a programmable signed kernel, adds a bias, then applies ReLU, a right shift and unsigned 8-bit saturation. It sits directly downstream of the line buffer and emits one feature-map pixel per valid window, with row/column bookkeeping and an end-of-frame flag for the next layer.

---
 rtl/conv3x3_if.sv | 28 ++
 rtl/conv3x3_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_if.sv
// Bus bundle between the line-buffer/coefficient feeder and conv3x3_engine.
//   col_valid, row0..row2 : one padded pixel column (row0 oldest), unsigned
//   w_we, w_addr, w_data  : kernel/bias write port
//   out_data, out_valid, out_last : feature-map result stream
interface conv3x3_if;
    logic       col_valid;
    logic [7:0] row0;
    logic [7:0] row1;
    logic [7:0] row2;
    logic       w_we;
    logic [3:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;

    // Feeder side
    modport master (
        output col_valid, row0, row1, row2, w_we, w_addr, w_data,
        input  out_data, out_valid, out_last
    );

    // Engine side
    modport slave (
        input  col_valid, row0, row1, row2, w_we, w_addr, w_data,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: sliding window over line-buffer columns, signed
// kernel multiply, bias add, ReLU, right shift and unsigned 8-bit saturation.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears window, counters, coefficients, pipeline)
//   bus  - conv3x3_if.slave: column input, coefficient write port, result output
// Latency is three cycles from a completing column to out_valid; no stalls.
module conv3x3_engine #(
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned IMG_H   = 28,
    parameter int unsigned PADDING = 1,
    parameter int unsigned SHIFT   = 7
) (
    input  logic      clk,
    input  logic      rst,
    conv3x3_if.slave  bus
);

    localparam int unsigned TOTAL_W = IMG_W + 2 * PADDING;
    localparam int unsigned TOTAL_H = IMG_H + 2 * PADDING;
    localparam int unsigned CW      = $clog2(TOTAL_W);
    localparam int unsigned RW      = $clog2(TOTAL_H);
    localparam int unsigned PROD_W  = 17;
    localparam int unsigned ACC_W   = 21;
    localparam int unsigned COEF_N  = 9;

    logic [CW-1:0]            col_cnt;
    logic [RW-1:0]            row_cnt;
    logic [7:0]               win     [3][3];   // [row][col], index 0 = oldest
    logic [7:0]               win_nxt [3][3];
    logic signed [7:0]        kern    [COEF_N];
    logic [7:0]               bias_lo;
    logic [7:0]               bias_hi;
    logic signed [PROD_W-1:0] prod    [COEF_N];
    logic                     p_valid;
    logic                     p_last;
    logic signed [ACC_W-1:0]  acc;
    logic                     s_valid;
    logic                     s_last;

    logic                     col_end_c;
    logic                     row_end_c;
    logic                     win_done_c;
    logic signed [ACC_W-1:0]  acc_c;
    logic [ACC_W-1:0]         shifted_c;
    logic [7:0]               sat_c;

    assign col_end_c  = (col_cnt == CW'(TOTAL_W - 1));
    assign row_end_c  = (row_cnt == RW'(TOTAL_H - 1));
    assign win_done_c = bus.col_valid && (col_cnt >= CW'(2)) && (row_cnt >= RW'(2));

    // Next window contents; products are taken from this so the multiply
    // stage lines up with the column that completes the window.
    always_comb begin
        win_nxt = win;
        if (bus.col_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_nxt[r][0] = win[r][1];
                win_nxt[r][1] = win[r][2];
            end
            win_nxt[0][2] = bus.row0;
            win_nxt[1][2] = bus.row1;
            win_nxt[2][2] = bus.row2;
        end
    end

    // Padded-frame column/row position of the next accepted column
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (bus.col_valid) begin
            if (col_end_c) begin
                col_cnt <= '0;
                row_cnt <= row_end_c ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    // Window registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            win <= win_nxt;
        end
    end

    // Coefficient store; addresses 11..15 are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(COEF_N); i++) begin
                kern[i] <= '0;
            end
            bias_lo <= '0;
            bias_hi <= '0;
        end else if (bus.w_we) begin
            for (int i = 0; i < int'(COEF_N); i++) begin
                if (bus.w_addr == 4'(i)) begin
                    kern[i] <= bus.w_data;
                end
            end
            if (bus.w_addr == 4'd9) begin
                bias_lo <= bus.w_data;
            end
            if (bus.w_addr == 4'd10) begin
                bias_hi <= bus.w_data;
            end
        end
    end

    // Multiply stage: unsigned pixel x signed coefficient
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(COEF_N); i++) begin
                prod[i] <= '0;
            end
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    prod[r*3+c] <= PROD_W'($signed({1'b0, win_nxt[r][c]})) * PROD_W'(kern[r*3+c]);
                end
            end
            p_valid <= win_done_c;
            p_last  <= win_done_c && col_end_c && row_end_c;
        end
    end

    // Adder tree plus sign-extended bias
    always_comb begin
        acc_c = ACC_W'($signed({bias_hi, bias_lo}));
        for (int i = 0; i < int'(COEF_N); i++) begin
            acc_c = acc_c + ACC_W'(prod[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
        end else begin
            acc     <= acc_c;
            s_valid <= p_valid;
            s_last  <= p_last;
        end
    end

    // ReLU, shift, saturate
    always_comb begin
        shifted_c = '0;
        if (!acc[ACC_W-1]) begin
            shifted_c = $unsigned(acc) >> SHIFT;
        end
        sat_c = (shifted_c > ACC_W'(255)) ? 8'hFF : shifted_c[7:0];
    end

    // Output register; data holds between results
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            bus.out_valid <= s_valid;
            bus.out_last  <= s_last;
            if (s_valid) begin
                bus.out_data <= sat_c;
            end
        end
    end

endmodule
